// File: rtl/mul_share_arbiter.sv
// Round-robin share of one fixed-point multiplier among NUM_REQ requesters, one op in flight.
// GNT one cycle after REQ, DONE pulse L+2 cycles after ISSUE; a watchdog aborts a silent multiplier.
module mul_share_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                     CLK,
  input  logic                     RSTN,
  input  logic [NUM_REQ-1:0]       REQ,
  input  logic [NUM_REQ*WIDTH-1:0] A_IN,
  input  logic [NUM_REQ*WIDTH-1:0] B_IN,
  output logic [NUM_REQ-1:0]       GNT,
  output logic [NUM_REQ-1:0]       DONE,
  output logic [WIDTH-1:0]         RESULT,
  output logic                     RESULT_OVF,
  output logic                     ERR,
  input  logic                     ERR_CLR,
  output logic [WIDTH-1:0]         MUL_VALUE_A_IN,
  output logic [WIDTH-1:0]         MUL_VALUE_B_IN,
  output logic                     MUL_VALID_IN,
  input  logic [WIDTH-1:0]         MUL_VALUE_OUT,
  input  logic                     MUL_VALID_OUT,
  input  logic                     MUL_OVERFLOW
);
  localparam int         IW      = $clog2(NUM_REQ);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               state_q;
  logic [IW-1:0]        last_q;
  logic [7:0]           cnt_q;
  logic [NUM_REQ-1:0]   gnt_q, done_q;
  logic [WIDTH-1:0]     a_q, b_q, res_q;
  logic                 vin_q, ovf_q, err_q;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IW:0]          base, pick_off, pick_sum;
  logic [IW-1:0]        last_d;
  logic [WIDTH-1:0]     a_d, b_d;
  logic                 timeout, err_d;

  always_comb begin
    // Rotate the request vector so bit 0 is the requester right after the last winner.
    req_dbl  = {REQ, REQ};
    base     = {1'b0, last_q} + (IW+1)'(1);
    req_rot  = req_dbl[base +: NUM_REQ];
    pick_off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) pick_off = (IW+1)'(k);
    end
    pick_sum = base + pick_off;
    last_d   = (pick_sum >= (IW+1)'(NUM_REQ)) ? IW'(pick_sum - (IW+1)'(NUM_REQ)) : IW'(pick_sum);
    a_d      = '0;
    b_d      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (last_d == IW'(k)) begin
        a_d = A_IN[k*WIDTH +: WIDTH];
        b_d = B_IN[k*WIDTH +: WIDTH];
      end
    end
    timeout = (state_q == S_WAIT) && !MUL_VALID_OUT && (cnt_q == TO_LAST);
    err_d   = timeout ? 1'b1 : (ERR_CLR ? 1'b0 : err_q);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NUM_REQ - 1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      vin_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= err_d;
      case (state_q)
        S_IDLE: begin
          if (|REQ) begin
            a_q     <= a_d;
            b_q     <= b_d;
            gnt_q   <= NUM_REQ'(1) << last_d;
            last_q  <= last_d;
            vin_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          vin_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 8'd1;
          if (MUL_VALID_OUT) begin
            res_q   <= MUL_VALUE_OUT;
            ovf_q   <= MUL_OVERFLOW;
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end else if (timeout) begin
            res_q   <= '0;
            ovf_q   <= 1'b1;
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= '0;
          gnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign GNT            = gnt_q;
  assign DONE           = done_q;
  assign RESULT         = res_q;
  assign RESULT_OVF     = ovf_q;
  assign ERR            = err_q;
  assign MUL_VALUE_A_IN = a_q;
  assign MUL_VALUE_B_IN = b_q;
  assign MUL_VALID_IN   = vin_q;
endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter with a saturating Q4.3 multiplier model (FRAC_BITS=3).
module tb_mul_share_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int LAT = 2;

  logic         CLK = 1'b0;
  logic         RSTN;
  logic [N-1:0] REQ;
  logic [N*W-1:0] A_IN, B_IN;
  logic [N-1:0] GNT, DONE;
  logic [W-1:0] RESULT;
  logic         RESULT_OVF, ERR, ERR_CLR;
  logic [W-1:0] MUL_VALUE_A_IN, MUL_VALUE_B_IN, MUL_VALUE_OUT;
  logic         MUL_VALID_IN, MUL_VALID_OUT, MUL_OVERFLOW;

  always #5 CLK = ~CLK;

  mul_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT_CYCLES(15)) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .A_IN(A_IN), .B_IN(B_IN),
    .GNT(GNT), .DONE(DONE), .RESULT(RESULT), .RESULT_OVF(RESULT_OVF),
    .ERR(ERR), .ERR_CLR(ERR_CLR),
    .MUL_VALUE_A_IN(MUL_VALUE_A_IN), .MUL_VALUE_B_IN(MUL_VALUE_B_IN),
    .MUL_VALID_IN(MUL_VALID_IN), .MUL_VALUE_OUT(MUL_VALUE_OUT),
    .MUL_VALID_OUT(MUL_VALID_OUT), .MUL_OVERFLOW(MUL_OVERFLOW)
  );

  // Multiplier model: VALID_OUT appears LAT cycles after the first WAIT cycle.
  int         mcnt = 0;
  logic [7:0] ma = 8'h00, mb = 8'h00;
  bit         mul_hang = 1'b0;
  int         prod;

  always @(posedge CLK) begin
    if (MUL_VALID_IN === 1'b1 && !mul_hang) begin
      mcnt <= LAT + 1;
      ma   <= MUL_VALUE_A_IN;
      mb   <= MUL_VALUE_B_IN;
    end else if (mcnt != 0) begin
      mcnt <= mcnt - 1;
    end
  end

  assign MUL_VALID_OUT = (mcnt == 1);

  always_comb begin
    prod          = (int'($signed(ma)) * int'($signed(mb))) >>> 3;
    MUL_VALUE_OUT = prod[7:0];
    MUL_OVERFLOW  = 1'b0;
    if (prod > 127) begin
      MUL_VALUE_OUT = 8'h7F;
      MUL_OVERFLOW  = 1'b1;
    end else if (prod < -128) begin
      MUL_VALUE_OUT = 8'h80;
      MUL_OVERFLOW  = 1'b1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [N-1:0] done; logic [W-1:0] res; logic ovf; } exp_t;
  exp_t sb[$];
  exp_t e;

  task automatic sb_push(input logic [N-1:0] d, input logic [W-1:0] r, input logic o);
    exp_t x;
    x.done = d;
    x.res  = r;
    x.ovf  = o;
    sb.push_back(x);
  endtask

  always @(negedge CLK) begin
    if (RSTN === 1'b1 && DONE !== '0) begin
      if (sb.size() == 0) begin
        check("done_unexpected", 32'(DONE), 32'h0);
      end else begin
        e = sb.pop_front();
        check("done", 32'(DONE), 32'(e.done));
        check("gnt_at_done", 32'(GNT), 32'(e.done));
        check("result", 32'(RESULT), 32'(e.res));
        check("result_ovf", 32'(RESULT_OVF), 32'(e.ovf));
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_gnt"}, 32'(GNT), 32'h0);
    check({tag, "_done"}, 32'(DONE), 32'h0);
    check({tag, "_mul_vin"}, 32'(MUL_VALID_IN), 32'h0);
    check({tag, "_mul_a"}, 32'(MUL_VALUE_A_IN), 32'h0);
    check({tag, "_mul_b"}, 32'(MUL_VALUE_B_IN), 32'h0);
    check({tag, "_result"}, 32'(RESULT), 32'h0);
    check({tag, "_ovf"}, 32'(RESULT_OVF), 32'h0);
    check({tag, "_err"}, 32'(ERR), 32'h0);
  endtask

  // One request: grant timing, operand capture, one-cycle VALID_IN, DONE latency.
  task automatic run_one(input logic [N-1:0] req, input int r, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic ovf, input int lat, input bit scramble);
    logic [N-1:0] oh;
    int n;
    oh = N'(1) << r;
    @(negedge CLK);
    REQ = req;
    A_IN[r*W +: W] = a;
    B_IN[r*W +: W] = b;
    sb_push(oh, res, ovf);
    @(negedge CLK);
    check("gnt", 32'(GNT), 32'(oh));
    check("mul_vin_high", 32'(MUL_VALID_IN), 32'h1);
    check("mul_a", 32'(MUL_VALUE_A_IN), 32'(a));
    check("mul_b", 32'(MUL_VALUE_B_IN), 32'(b));
    REQ = '0;
    if (scramble) begin
      A_IN[r*W +: W] = 8'h7F;
      B_IN[r*W +: W] = 8'h55;
    end
    @(negedge CLK);
    n = 1;
    check("mul_vin_pulse", 32'(MUL_VALID_IN), 32'h0);
    while (DONE === '0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("done_latency", 32'(n), 32'(lat));
  endtask

  typedef struct { logic [N-1:0] req; int r; logic [7:0] a; logic [7:0] b; logic [7:0] res; logic ovf; bit scr; } vec_t;
  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int seen, n;
    vecs[0] = '{4'b0001, 0, 8'h10, 8'h18, 8'h30, 1'b0, 1'b0};
    vecs[1] = '{4'b0100, 2, 8'h7F, 8'h7F, 8'h7F, 1'b1, 1'b0};
    vecs[2] = '{4'b0010, 1, 8'hF0, 8'h18, 8'hD0, 1'b0, 1'b1};
    vecs[3] = '{4'b0001, 0, 8'h08, 8'h05, 8'h05, 1'b0, 1'b0};
    vecs[4] = '{4'b0010, 1, 8'hF8, 8'h18, 8'hE8, 1'b0, 1'b0};
    vecs[5] = '{4'b1000, 3, 8'h80, 8'h7F, 8'h80, 1'b1, 1'b0};

    RSTN = 1'b0; REQ = '0; A_IN = '0; B_IN = '0; ERR_CLR = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset("rst");
    RSTN = 1'b1;

    for (int i = 0; i < 6; i++)
      run_one(vecs[i].req, vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ovf, 4, vecs[i].scr);

    // All four requesting continuously: expected order 0,1,2,3,0,1.
    @(negedge CLK);
    for (int k = 0; k < N; k++) begin
      A_IN[k*W +: W] = 8'h08;
      B_IN[k*W +: W] = 8'(k + 1);
    end
    for (int j = 0; j < 6; j++) sb_push(N'(1) << (j % N), 8'((j % N) + 1), 1'b0);
    REQ = 4'b1111;
    seen = 0;
    n = 0;
    while (seen < 6 && n < 200) begin
      @(negedge CLK);
      n++;
      if (DONE !== '0) seen++;
    end
    REQ = '0;
    check("rr_done_count", 32'(seen), 32'd6);

    // Silent multiplier: abort after 15 WAIT cycles, sticky ERR, then clear.
    mul_hang = 1'b1;
    run_one(4'b0010, 1, 8'h10, 8'h10, 8'h00, 1'b1, 16, 1'b0);
    check("err_set", 32'(ERR), 32'h1);
    repeat (2) @(negedge CLK);
    check("err_sticky", 32'(ERR), 32'h1);
    ERR_CLR = 1'b1;
    @(negedge CLK);
    check("err_cleared", 32'(ERR), 32'h0);
    run_one(4'b0100, 2, 8'h10, 8'h10, 8'h00, 1'b1, 16, 1'b0);
    check("err_set_wins", 32'(ERR), 32'h1);
    @(negedge CLK);
    check("err_clr_after", 32'(ERR), 32'h0);
    ERR_CLR = 1'b0;
    mul_hang = 1'b0;
    run_one(4'b0001, 0, 8'h10, 8'h18, 8'h30, 1'b0, 4, 1'b0);
    check("err_after_clean", 32'(ERR), 32'h0);

    // Reset while waiting on the multiplier; its late VALID_OUT must be ignored.
    @(negedge CLK);
    REQ = 4'b0001;
    A_IN[0 +: W] = 8'h10;
    B_IN[0 +: W] = 8'h18;
    @(negedge CLK);
    check("rst_mid_gnt", 32'(GNT), 32'h1);
    REQ = '0;
    @(negedge CLK);
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    check_reset("rst_mid");
    repeat (3) begin
      @(negedge CLK);
      check("rst_mid_no_done", 32'(DONE), 32'h0);
    end
    check("rst_mid_result", 32'(RESULT), 32'h0);
    run_one(4'b1000, 3, 8'h18, 8'h10, 8'h30, 1'b0, 4, 1'b0);

    @(negedge CLK);
    RSTN = 1'b0;
    @(negedge CLK);
    RSTN = 1'b1;
    run_one(4'b1001, 0, 8'h08, 8'hF8, 8'hF8, 1'b0, 4, 1'b0);

    repeat (3) @(negedge CLK);
    check("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
